// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: datapath width, reset/bubble
// defaults and the instruction-fetch state encoding.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP           = 32'h0000_0004;
    localparam logic [XLEN-1:0] WORD_ALIGN_MASK   = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_WAIT  = 2'd2,
        FS_HOLD  = 2'd3
    } fetch_state_e;

    // Force a byte address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/adder32.sv
// Shared 32-bit combinational adder; carry-out is discarded so sums wrap
// modulo 2^32.
module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    assign y = a + b;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Update priority is flush, then stall, then load,
// otherwise a bubble is inserted.
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            stall,
    input  logic            load,
    input  logic [XLEN-1:0] load_instr,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_pc4,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4
);

    logic            valid_r;
    logic [XLEN-1:0] instr_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc4_r;

    // Pipeline register; pc fields only change on a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            instr_r <= NOP_INSTR;
            pc_r    <= 32'h0000_0000;
            pc4_r   <= 32'h0000_0000;
        end else if (flush) begin
            valid_r <= 1'b0;
            instr_r <= NOP_INSTR;
        end else if (stall) begin
            valid_r <= valid_r;
        end else if (load) begin
            valid_r <= 1'b1;
            instr_r <= load_instr;
            pc_r    <= load_pc;
            pc4_r   <= load_pc4;
        end else begin
            valid_r <= 1'b0;
            instr_r <= NOP_INSTR;
        end
    end

    assign valid = valid_r;
    assign instr = instr_r;
    assign pc    = pc_r;
    assign pc4   = pc4_r;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding word fetch at a
// time, absorbs decode stalls in a one-entry buffer and handles EX redirects.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            if_id_valid_o,
    output logic [XLEN-1:0] if_id_instr_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_pc4_o,
    output logic [XLEN-1:0] pc_o
);

    fetch_state_e    state_r;
    fetch_state_e    state_next_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_next_s;
    logic            kill_r;
    logic            kill_next_s;
    logic [XLEN-1:0] buf_instr_r;
    logic [XLEN-1:0] buf_pc_r;
    logic [XLEN-1:0] buf_pc4_r;
    logic            buf_load_s;

    logic [XLEN-1:0] pc4_s;
    logic [XLEN-1:0] target_s;
    logic            deliver_s;
    logic [XLEN-1:0] deliver_instr_s;
    logic [XLEN-1:0] deliver_pc_s;
    logic [XLEN-1:0] deliver_pc4_s;

    adder32 u_pc_inc (
        .a (pc_r),
        .b (PC_STEP),
        .y (pc4_s)
    );

    assign target_s = word_align(redirect_pc_i);

    // Next-state, PC, kill and deliver selection.
    always_comb begin
        state_next_s    = state_r;
        pc_next_s       = pc_r;
        kill_next_s     = kill_r;
        buf_load_s      = 1'b0;
        deliver_s       = 1'b0;
        deliver_instr_s = imem_rdata_i;
        deliver_pc_s    = pc_r;
        deliver_pc4_s   = pc4_s;
        case (state_r)
            FS_IDLE: begin
                state_next_s = FS_FETCH;
            end
            FS_FETCH: begin
                state_next_s = FS_WAIT;
                if (redirect_i) begin
                    pc_next_s   = target_s;
                    kill_next_s = 1'b1;
                end else begin
                    kill_next_s = kill_r;
                end
            end
            FS_WAIT: begin
                // A killed or redirected response is dropped; the fetch at the
                // new PC is only issued once the in-flight one has returned.
                if (imem_rvalid_i && (kill_r || redirect_i)) begin
                    kill_next_s  = 1'b0;
                    state_next_s = FS_FETCH;
                    if (redirect_i) begin
                        pc_next_s = target_s;
                    end else begin
                        pc_next_s = pc_r;
                    end
                end else if (redirect_i) begin
                    pc_next_s   = target_s;
                    kill_next_s = 1'b1;
                end else if (imem_rvalid_i && !stall_i) begin
                    deliver_s    = 1'b1;
                    pc_next_s    = pc4_s;
                    state_next_s = FS_FETCH;
                end else if (imem_rvalid_i) begin
                    buf_load_s   = 1'b1;
                    state_next_s = FS_HOLD;
                end else begin
                    state_next_s = FS_WAIT;
                end
            end
            FS_HOLD: begin
                deliver_instr_s = buf_instr_r;
                deliver_pc_s    = buf_pc_r;
                deliver_pc4_s   = buf_pc4_r;
                if (redirect_i) begin
                    pc_next_s    = target_s;
                    state_next_s = FS_FETCH;
                end else if (!stall_i) begin
                    deliver_s    = 1'b1;
                    pc_next_s    = pc4_s;
                    state_next_s = FS_FETCH;
                end else begin
                    state_next_s = FS_HOLD;
                end
            end
            default: begin
                state_next_s = FS_IDLE;
            end
        endcase
    end

    // FSM, PC and kill flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FS_IDLE;
            pc_r    <= RESET_PC;
            kill_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            kill_r  <= kill_next_s;
        end
    end

    // One-entry stall buffer; contents are only meaningful in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_instr_r <= NOP_INSTR;
            buf_pc_r    <= 32'h0000_0000;
            buf_pc4_r   <= 32'h0000_0000;
        end else if (buf_load_s) begin
            buf_instr_r <= imem_rdata_i;
            buf_pc_r    <= pc_r;
            buf_pc4_r   <= pc4_s;
        end else begin
            buf_instr_r <= buf_instr_r;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush_i),
        .stall      (stall_i),
        .load       (deliver_s),
        .load_instr (deliver_instr_s),
        .load_pc    (deliver_pc_s),
        .load_pc4   (deliver_pc4_s),
        .valid      (if_id_valid_o),
        .instr      (if_id_instr_o),
        .pc         (if_id_pc_o),
        .pc4        (if_id_pc4_o)
    );

    assign imem_req_o  = (state_r == FS_FETCH);
    assign imem_addr_o = pc_r;
    assign pc_o        = pc_r;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC register and issues word fetches to instruction memory, at most one outstanding at a time. It feeds the IF/ID pipeline register and handles decode stalls, flushes and EX-stage branch/jump redirects. PC+4 is produced with the team's existing 32-bit combinational adder.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, bubble encoding (sll $0,$0,0).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
stall_i  input  1  hazard unit: hold IF/ID contents.
flush_i  input  1  hazard unit: invalidate IF/ID.
redirect_i  input  1  EX: taken branch or jump.
redirect_pc_i  input  32  redirect target. Bits [1:0] are forced to 0.
imem_req_o  output  1  fetch request, asserted for one cycle per fetch.
imem_addr_o  output  32  fetch address, equal to pc when imem_req_o=1.
imem_rvalid_i  input  1  response valid; arrives at least 1 cycle after the request.
imem_rdata_i  input  32  fetched instruction.
if_id_valid_o  output  1  IF/ID holds a real instruction.
if_id_instr_o  output  32  IF/ID instruction.
if_id_pc_o  output  32  IF/ID instruction address.
if_id_pc4_o  output  32  IF/ID pc+4.
pc_o  output  32  current fetch PC (debug/trace).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC, state=IDLE, kill=0, buffer empty.
  - if_id_valid_o=0, if_id_instr_o=NOP_INSTR, if_id_pc_o=0, if_id_pc4_o=0.
  - imem_req_o=0 and imem_addr_o=pc (combinational from state).
- State IDLE: req=0. Moves to FETCH on the next clock.
- State FETCH: req=1, addr=pc. Always moves to WAIT; memory accepts every request.
  - If redirect_i is high in the same cycle, the request is still issued, and on the clock pc<=target and kill<=1.
- State WAIT: req=0. The following cases are evaluated in priority order.
  - Response with kill=1, or response with redirect_i=1: drop the response, kill<=0, go to FETCH. A concurrent redirect sets pc<=target.
  - Redirect without a response: pc<=target, kill<=1, stay in WAIT.
  - Response with stall_i=0: deliver to IF/ID, pc<=pc+4, go to FETCH.
  - Response with stall_i=1: capture {instr, pc, pc+4} in the 1-entry buffer, go to HOLD.
- State HOLD: req=0.
  - redirect_i: discard the buffer, pc<=target, go to FETCH.
  - stall_i=0: deliver the buffer to IF/ID, pc<=pc+4, go to FETCH.
  - Otherwise: stay in HOLD.
- imem_rvalid_i is ignored in IDLE, FETCH and HOLD, so a stale response after reset is ignored.
- IF/ID update priority: flush_i first, then stall_i, then deliver, then bubble.
  - flush_i: valid<=0, instr<=NOP_INSTR. pc fields are don't-care but hold their values.
  - stall_i: hold all fields.
  - deliver: load the fields, valid<=1.
  - bubble (no flush, no stall, nothing to deliver): valid<=0, instr<=NOP_INSTR.
- flush_i coinciding with a deliver: the fetched instruction is lost. The hazard unit never asserts flush without also asserting redirect.
- redirect_i does not itself clear IF/ID; flush_i does that.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. pc[1:0] is always 0.
- Throughput: one instruction per 2 cycles with 1-cycle memory latency (FETCH then WAIT). A deliver and the next FETCH never overlap.
- Latency from redirect to the first fetch at the target: 1 cycle in HOLD; in WAIT, 1 cycle after the in-flight response arrives.

Decomposition:
- Shared package mips_pkg holds:
  - the NOP_INSTR and RESET_PC defaults;
  - the fetch state encoding (IDLE=2'd0, FETCH=2'd1, WAIT=2'd2, HOLD=2'd3);
  - the width constant XLEN=32.
- One sub-module, if_id_reg: IF/ID register with flush/stall/load priority and reset values as above.
- The FSM, PC, kill flag and buffer stay in if_fetch_stage. The PC+4 increment instantiates the existing adder.

Test Plan:
- Reset, then memory with 1-cycle latency returning 0x2008_0005 at 0x0: IDLE, FETCH addr=0, WAIT. Next cycle if_id_valid=1, instr=0x2008_0005, pc=0, pc4=4. Then FETCH addr=4.
- stall_i held 3 cycles while the response to 0x4 arrives: IF/ID unchanged, state HOLD, no imem_req. On release, IF/ID gets the instruction at 0x4, then FETCH addr=8.
- redirect_i=1, redirect_pc_i=0x0000_0042 in WAIT, with the response 2 cycles later: response dropped, if_id_valid stays 0, next FETCH addr=0x40.
- redirect_i and imem_rvalid_i in the same WAIT cycle, target 0x100: response dropped, kill stays 0, FETCH addr=0x100.
- Redirect to 0xFFFF_FFFC, then let it run: fetch at 0xFFFF_FFFC, if_id_pc4=0, next FETCH addr=0.
- rst_n pulsed low while in WAIT, then a response arrives in IDLE: all outputs return to reset values, response ignored, first fetch at RESET_PC.
